gate_preact_mac: RTL

Sequential multiply-accumulate stage that computes one GRU gate pre-activation, z = b + sum(w_i * a_i), in Q(INT_WIDTH.FRAC_WIDTH) fixed point. It sits directly upstream of the sigmoid/piecewise-linear activation. Its registered, saturated output y feeds the activation's x input. Operand pairs (weight, activation) stream in through a valid/ready handshake, and the result leaves through a valid/ready handshake.

---
 rtl/gru_fixed_pkg.sv | 10 +
 rtl/fixed_narrow_sat.sv | 23 ++
 rtl/gate_preact_mac.sv | 65 ++++++
 3 files changed

// File: rtl/gru_fixed_pkg.sv
// gru_fixed_pkg: shared Q-format widths, fixed-point type, saturation limits and MAC states
package gru_fixed_pkg;
   localparam int INT_WIDTH  = 8;
   localparam int FRAC_WIDTH = 8;
   localparam int WIDTH      = INT_WIDTH + FRAC_WIDTH;
   typedef logic signed [WIDTH-1:0] fixed_t;
   localparam fixed_t FIXED_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam fixed_t FIXED_MIN = {1'b1, {(WIDTH-1){1'b0}}};
   typedef enum logic [1:0] {IDLE, ACCUM, SAT, OUT} mac_state_t;
endpackage

// File: rtl/fixed_narrow_sat.sv
// fixed_narrow_sat: narrows a wide Q accumulator to WIDTH with saturation; GATE_PREACT_ROUND_EN selects round-half-up instead of floor
module fixed_narrow_sat #(
   parameter int WIDTH      = 16,
   parameter int FRAC_WIDTH = 8,
   parameter int ACC_WIDTH  = 37
) (
   input  logic [ACC_WIDTH-1:0] acc,
   output logic [WIDTH-1:0]     y
);
   localparam logic signed [ACC_WIDTH-1:0] HI = {{(ACC_WIDTH-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] LO = {{(ACC_WIDTH-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
   logic signed [ACC_WIDTH-1:0] rnd;
   logic signed [ACC_WIDTH-1:0] shifted;
`ifdef GATE_PREACT_ROUND_EN
   // the accumulator has spare headroom, so adding half an LSB cannot wrap
   assign rnd = acc + (ACC_WIDTH'(1) << (FRAC_WIDTH-1));
`else
   assign rnd = acc;
`endif
   assign shifted = rnd >>> FRAC_WIDTH;
   assign y = shifted > HI ? {1'b0, {(WIDTH-1){1'b1}}} :
              shifted < LO ? {1'b1, {(WIDTH-1){1'b0}}} : shifted[WIDTH-1:0];
endmodule

// File: rtl/gate_preact_mac.sv
// gate_preact_mac: streaming MAC computing one GRU gate pre-activation b + sum(w*a); optional GATE_PREACT_ROUND_EN rounding in narrowing
module gate_preact_mac import gru_fixed_pkg::*; #(
   parameter int INT_WIDTH  = 8,
   parameter int FRAC_WIDTH = 8,
   parameter int WIDTH      = INT_WIDTH + FRAC_WIDTH,
   parameter int MAX_TERMS  = 16,
   parameter int ACC_WIDTH  = 2*WIDTH + $clog2(MAX_TERMS) + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] bias,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_w,
   input  logic [WIDTH-1:0] in_a,
   input  logic             in_last,
   output logic             y_valid,
   input  logic             y_ready,
   output logic [WIDTH-1:0] y,
   output logic             busy
);
   localparam int CW = $clog2(MAX_TERMS);
   mac_state_t state;
   logic signed [ACC_WIDTH-1:0] acc;
   logic [CW-1:0] count;
   logic signed [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0] sat;
   assign prod = $signed(in_w) * $signed(in_a);
   assign in_ready = state == ACCUM;
   assign y_valid = state == OUT;
   assign busy = state != IDLE;
   fixed_narrow_sat #(.WIDTH(WIDTH), .FRAC_WIDTH(FRAC_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_sat (
      .acc (acc),
      .y   (sat)
   );
   // sequencer: load bias, accumulate beats until last or the term limit, narrow, then hold the result
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state <= IDLE;
         acc   <= '0;
         count <= '0;
         y     <= '0;
      end else
         case (state)
            IDLE:
               if (start) begin
                  acc   <= ACC_WIDTH'($signed(bias)) <<< FRAC_WIDTH;
                  count <= '0;
                  state <= ACCUM;
               end
            ACCUM:
               if (in_valid) begin
                  acc   <= acc + ACC_WIDTH'(prod);
                  count <= count + 1'b1;
                  if (in_last || count == CW'(MAX_TERMS-1)) state <= SAT;
               end
            SAT: begin
               y     <= sat;
               state <= OUT;
            end
            OUT:
               if (y_ready) state <= IDLE;
         endcase
endmodule
